// File: rtl/tick_meter_pkg.sv
// -----------------------------------------------------------------------------
// tick_meter_pkg
// Shared definitions for the tick period meter: default parameter values and
// the measurement FSM state encoding.
// No ports.
// -----------------------------------------------------------------------------
package tick_meter_pkg;

    localparam int DEF_CNT_W      = 27;
    localparam int DEF_EXP_PERIOD = 50_000_000;
    localparam int DEF_TOL        = 1024;

    // Fixed encodings, kept as plain constants so legacy code and register
    // dumps can decode the state without the enum type.
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_MEASURE = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;
    localparam logic [1:0] ST_LOST    = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE    = ST_IDLE,
        S_MEASURE = ST_MEASURE,
        S_LOCKED  = ST_LOCKED,
        S_LOST    = ST_LOST
    } meter_state_e;

endpackage

// File: rtl/tick_period_meter_sync_rise_det.sv
// -----------------------------------------------------------------------------
// sync_rise_det
// Brings the asynchronous tick input into the clk domain through a 2-flop
// synchronizer, optionally debounces it, and emits a registered one-cycle
// rising-edge pulse.
//
// Build option: TICK_PERIOD_METER_GLITCH_FILTER_EN
//   defined   - the level only changes after 3 consecutive equal synchronized
//               samples; rise_o appears 5 clk after a tick_i 0->1.
//   undefined - the synchronizer output is used directly; rise_o appears
//               3 clk after a tick_i 0->1.
//
// Ports
//   clk     in   system clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   tick_i  in   slow square wave, asynchronous to clk
//   rise_o  out  one-cycle pulse per detected rising edge
// -----------------------------------------------------------------------------
module sync_rise_det (
    input  logic clk,
    input  logic rst_n,
    input  logic tick_i,
    output logic rise_o
);

    logic sync1_q;
    logic sync2_q;
    logic level_q;
    logic level_d;
    logic rise_q;

`ifdef TICK_PERIOD_METER_GLITCH_FILTER_EN
    logic hist1_q;
    logic hist2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist1_q <= 1'b0;
            hist2_q <= 1'b0;
        end else begin
            hist1_q <= sync2_q;
            hist2_q <= hist1_q;
        end
    end

    // Accept a new level only when the current sample and the two previous
    // ones agree; anything shorter than three clk is treated as a glitch.
    always_comb begin
        level_d = level_q;
        if ((sync2_q == hist1_q) && (hist1_q == hist2_q)) begin
            level_d = sync2_q;
        end
    end
`else
    always_comb begin
        level_d = sync2_q;
    end
`endif

    // The edge is judged on level_d so that the filtered build adds exactly
    // the two cycles needed to collect its extra samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= tick_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            rise_q  <= level_d & ~level_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/tick_period_meter.sv
// -----------------------------------------------------------------------------
// tick_period_meter
// Measures the rising-edge-to-rising-edge period of a slow asynchronous tick
// in clk cycles, reports each new measurement, and tracks whether the tick is
// within EXP_PERIOD +/- TOL (locked) or has gone missing (timeout).
//
// Build option: TICK_PERIOD_METER_GLITCH_FILTER_EN (see sync_rise_det) adds a
// 3-sample glitch filter in front of edge detection.
//
// Parameters
//   CNT_W       period counter width
//   EXP_PERIOD  expected tick period in clk cycles
//   TOL         allowed +/- deviation from EXP_PERIOD in clk cycles
//
// Ports
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset (release synchronized
//                    by the integrating top level)
//   tick_in     in   slow square wave, asynchronous to clk
//   period      out  last measured period in clk cycles
//   period_vld  out  one-cycle pulse when period updates
//   locked      out  high while in LOCKED
//   timeout     out  high while in LOST
//   edge_cnt    out  count of detected rising edges, wraps at 255
//
// State     | meaning
// ----------+-----------------------------------------------------------------
// IDLE      | out of reset, waiting for the first edge (no reference yet)
// MEASURE   | have a reference edge, last period out of tolerance or unknown
// LOCKED    | last measured period within EXP_PERIOD +/- TOL
// LOST      | no edge for 2*EXP_PERIOD cycles; next edge restarts measuring
// -----------------------------------------------------------------------------
module tick_period_meter
    import tick_meter_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int EXP_PERIOD = DEF_EXP_PERIOD,
    parameter int TOL        = DEF_TOL
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick_in,
    output logic [CNT_W-1:0] period,
    output logic             period_vld,
    output logic             locked,
    output logic             timeout,
    output logic [7:0]       edge_cnt
);

    // One extra bit so the absolute difference never wraps, whatever the
    // measured period is.
    localparam logic [CNT_W:0] EXP_W    = (CNT_W + 1)'(EXP_PERIOD);
    localparam logic [CNT_W:0] TOL_W    = (CNT_W + 1)'(TOL);
    // Wide enough that 2*EXP_PERIOD never truncates; if it exceeds the
    // counter range the saturated counter simply never reaches it.
    localparam logic [63:0]    LOST_LIM = 64'(EXP_PERIOD) * 64'd2;

    logic             rise;
    meter_state_e     state_q;
    meter_state_e     state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] period_d;
    logic             vld_q;
    logic             vld_d;
    logic [7:0]       edge_cnt_q;
    logic [7:0]       edge_cnt_d;
    logic [CNT_W:0]   diff;
    logic             in_tol;
    logic             lost_hit;
    logic             measuring;

    sync_rise_det u_sync_rise_det (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick_i (tick_in),
        .rise_o (rise)
    );

    always_comb begin
        measuring = (state_q == S_MEASURE) || (state_q == S_LOCKED);
        lost_hit  = 64'(cnt_q) >= LOST_LIM;

        if ({1'b0, period_q} >= EXP_W) begin
            diff = {1'b0, period_q} - EXP_W;
        end else begin
            diff = EXP_W - {1'b0, period_q};
        end
        in_tol = (diff <= TOL_W);
    end

    // Counter value k means k cycles have elapsed since the last rise, so the
    // value seen on the next rise is the period directly.
    always_comb begin
        cnt_d = cnt_q;
        if (rise) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Only an edge with a valid reference edge before it produces a period;
    // the first edge after reset or after LOST just starts the interval.
    always_comb begin
        period_d   = period_q;
        vld_d      = 1'b0;
        edge_cnt_d = edge_cnt_q;
        if (rise) begin
            edge_cnt_d = edge_cnt_q + 8'd1;
            if (measuring) begin
                period_d = cnt_q;
                vld_d    = 1'b1;
            end
        end
    end

    // The tolerance decision is taken on the published period, i.e. in the
    // cycle period_vld is high, so locked moves the cycle after the update.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (rise) begin
                    state_d = S_MEASURE;
                end else if (lost_hit) begin
                    state_d = S_LOST;
                end
            end
            S_MEASURE, S_LOCKED: begin
                if (!rise) begin
                    if (lost_hit) begin
                        state_d = S_LOST;
                    end else if (vld_q) begin
                        state_d = in_tol ? S_LOCKED : S_MEASURE;
                    end
                end
            end
            S_LOST: begin
                if (rise) begin
                    state_d = S_MEASURE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            period_q   <= '0;
            vld_q      <= 1'b0;
            edge_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            period_q   <= period_d;
            vld_q      <= vld_d;
            edge_cnt_q <= edge_cnt_d;
        end
    end

    assign period     = period_q;
    assign period_vld = vld_q;
    assign locked     = (state_q == S_LOCKED);
    assign timeout    = (state_q == S_LOST);
    assign edge_cnt   = edge_cnt_q;

endmodule

// File: doc/tick_period_meter.md
TICK_PERIOD_METER -- requires
Module: tick_period_meter

Interface
REQ-001 SHALL have parameter CNT_W, default 27, period counter width.
REQ-002 SHALL have parameter EXP_PERIOD, default 50000000, expected tick period in clk cycles.
REQ-003 SHALL have parameter TOL, default 1024, allowed +/- deviation from EXP_PERIOD in clk cycles.
REQ-004 SHALL have input clk, 1 bit, single system clock; all logic on its rising edge.
REQ-005 SHALL have input rst_n, 1 bit, reset, asynchronous assert, active-low.
REQ-006 SHALL have input tick_in, 1 bit, slow square wave, asynchronous to clk.
REQ-007 SHALL have output period, CNT_W bits, last measured rising-edge-to-rising-edge period in clk cycles.
REQ-008 SHALL have output period_vld, 1 bit, one-cycle pulse when period updates.
REQ-009 SHALL have output locked, 1 bit, high while in LOCKED.
REQ-010 SHALL have output timeout, 1 bit, high while in LOST.
REQ-011 SHALL have output edge_cnt, 8 bits, count of detected rising edges.

Function
REQ-012 SHALL pass tick_in through a 2-flop synchronizer, then flag a rising edge (rise) on synchronized 0->1; rise asserts 3 clk after a tick_in 0->1 that meets setup.
REQ-013 SHALL run a free counter that resets to 1 on the cycle after rise, otherwise increments, saturating at all-ones.
REQ-014 On rise, period SHALL capture the counter value, and period_vld SHALL pulse the next cycle, except on the first rise after reset or after LOST.
REQ-015 SHALL implement FSM IDLE, MEASURE, LOCKED, LOST.
REQ-016 IDLE: first rise -> MEASURE, no period_vld.
REQ-017 MEASURE/LOCKED: on rise, |period - EXP_PERIOD| <= TOL -> LOCKED; otherwise -> MEASURE.
REQ-018 Any state except LOST: counter reaching 2*EXP_PERIOD -> LOST; if rise coincides with that cycle, rise wins.
REQ-019 LOST: next rise -> MEASURE, treated as first edge (no period_vld), counter restarts.
REQ-020 edge_cnt SHALL increment on every rise in all states and wrap 255 -> 0.
REQ-021 Tolerance compare SHALL use CNT_W+1-bit unsigned difference; no overflow for any period value.

Reset
REQ-022 rst_n low SHALL immediately force state IDLE, synchronizer flops 0, counter 0, period 0, period_vld 0, locked 0, timeout 0, edge_cnt 0.
REQ-023 Reset asserted mid-measurement SHALL discard the partial count; no period_vld is emitted for the interrupted interval.
REQ-024 Deassertion SHALL be synchronized to clk by the integrating top level; the block requires none internally.

Configuration
REQ-025 With TICK_PERIOD_METER_GLITCH_FILTER_EN defined, the synchronized input SHALL update only after 3 consecutive equal samples, adding 2 clk of latency (rise at 5 clk); shorter pulses are ignored.
REQ-026 Without the macro, the synchronizer output SHALL feed edge detection directly (REQ-012 latency).

Structure
REQ-027 A shared package tick_meter_pkg SHALL hold the FSM state enum and default EXP_PERIOD/TOL constants.
REQ-028 Synchronizer, optional glitch filter and edge detect SHALL be one sub-module, sync_rise_det.

Verification (bench uses EXP_PERIOD=100, TOL=2, CNT_W=8)
REQ-029 Reset, then tick_in with period 100 clk, 5 periods -> no period_vld on first edge; period=100 with period_vld on each later edge; locked=1 after the 2nd edge; edge_cnt=5.
REQ-030 Locked, then one period of 103 -> period=103, locked falls the cycle after the update; next 100 period -> locked=1.
REQ-031 Locked, then tick_in held low 200 clk -> timeout=1, locked=0; next edge -> timeout=0, MEASURE, no period_vld.
REQ-032 Assert rst_n low mid-period, then release and apply periods of 100 -> all outputs 0 during reset; the first post-reset edge produces no period_vld.
REQ-033 260 edges -> edge_cnt wraps to 4.
REQ-034 Macro defined: 1-clk high glitch on tick_in -> no rise, edge_cnt unchanged; macro undefined: the same glitch, if sampled, counts as an edge.
